// File: rtl/collector.sv
// collector: polls a bank of encrypter cores round-robin, captures one ready
// word at a time with a one-cycle acknowledge, and streams it out
// most-significant nibble first under QSPI flow control.
module collector #(
  parameter  int NUM_ENCRYPTERS  = 4,
  parameter  int ENCRYPTER_WIDTH = 32,
  localparam int NIBBLES         = ENCRYPTER_WIDTH / 4,
  localparam int IDX_W           = $clog2(NUM_ENCRYPTERS),
  localparam int SUB_W           = $clog2(ENCRYPTER_WIDTH),
  localparam int CNT_W           = $clog2(NIBBLES) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [3:0]                 qspi_data,
  output logic                       qspi_sending,
  input  logic                       qspi_ready,
  input  logic [ENCRYPTER_WIDTH-1:0] encrypters_data [NUM_ENCRYPTERS],
  input  logic [NUM_ENCRYPTERS-1:0]  encrypters_data_ready,
  output logic [NUM_ENCRYPTERS-1:0]  encrypters_capture,
  output logic [1:0]                 state_out,
  output logic [ENCRYPTER_WIDTH-1:0] encrypter_data_packe_out,
  output logic [SUB_W-1:0]           encrypter_data_subindex_out,
  output logic [IDX_W-1:0]           encrypter_index_out,
  output logic [CNT_W-1:0]           encrypter_data_index_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    NEXT    = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [ENCRYPTER_WIDTH-1:0]  packet_q, packet_d;
  logic [CNT_W-1:0]            data_index_q, data_index_d;
  logic [3:0]                  qspi_data_q, qspi_data_d;
  logic                        qspi_sending_q, qspi_sending_d;
  logic [NUM_ENCRYPTERS-1:0]   capture_q, capture_d;

  logic [NUM_ENCRYPTERS-1:0]   index_onehot;
  logic [3:0]                  nibble_arr [NIBBLES];
  logic [3:0]                  cur_nibble;
  logic [IDX_W-1:0]            next_index;

  // Decode the polled index to the acknowledge pattern, and split the
  // packet into nibbles with nibble 0 being the most significant one.
  for (genvar gi = 0; gi < NUM_ENCRYPTERS; gi++) begin : g_onehot
    assign index_onehot[gi] = (index_q == IDX_W'(gi));
  end

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nibble
    assign nibble_arr[gi] = packet_q[ENCRYPTER_WIDTH-1-4*gi -: 4];
  end

  // Select the nibble addressed by the count of nibbles already sent.
  always_comb begin
    cur_nibble = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (data_index_q == CNT_W'(i)) cur_nibble = nibble_arr[i];
    end
  end

  assign next_index = (index_q == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : index_q + IDX_W'(1);

  // Next-state and registered-output logic; sending and capture default low
  // so both are single-cycle unless explicitly re-asserted.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    packet_d       = packet_q;
    data_index_d   = data_index_q;
    qspi_data_d    = qspi_data_q;
    qspi_sending_d = 1'b0;
    capture_d      = '0;
    case (state_q)
      IDLE: begin
        if (encrypters_data_ready[index_q]) begin
          packet_d     = encrypters_data[index_q];
          capture_d    = index_onehot;
          data_index_d = '0;
          state_d      = CAPTURE;
        end else begin
          index_d = next_index;
        end
      end
      CAPTURE: state_d = SEND;
      SEND: begin
        if (qspi_ready) begin
          qspi_data_d    = cur_nibble;
          qspi_sending_d = 1'b1;
          data_index_d   = data_index_q + CNT_W'(1);
          if (data_index_q == CNT_W'(NIBBLES - 1)) state_d = NEXT;
        end
      end
      NEXT: begin
        // Move past the served encrypter so it is not rechecked first.
        index_d = next_index;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset to all zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      index_q        <= '0;
      packet_q       <= '0;
      data_index_q   <= '0;
      qspi_data_q    <= '0;
      qspi_sending_q <= 1'b0;
      capture_q      <= '0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      packet_q       <= packet_d;
      data_index_q   <= data_index_d;
      qspi_data_q    <= qspi_data_d;
      qspi_sending_q <= qspi_sending_d;
      capture_q      <= capture_d;
    end
  end

  assign qspi_data                   = qspi_data_q;
  assign qspi_sending                = qspi_sending_q;
  assign encrypters_capture          = capture_q;
  assign state_out                   = state_q;
  assign encrypter_data_packe_out    = packet_q;
  assign encrypter_data_subindex_out = SUB_W'({data_index_q, 2'b00});
  assign encrypter_index_out         = index_q;
  assign encrypter_data_index_out    = data_index_q;

endmodule

// File: tb/tb_collector.sv
// tb_collector: directed stimulus with a scoreboard; expected nibbles and
// capture pulses are queued by the stimulus and checked by a monitor.
module tb_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  qspi_data;
  logic        qspi_sending;
  logic        qspi_ready = 1'b1;
  logic [31:0] enc_data [4];
  logic [3:0]  enc_ready = 4'b0000;
  logic [3:0]  enc_capture;
  logic [1:0]  state_out;
  logic [31:0] packet_out;
  logic [4:0]  subindex_out;
  logic [1:0]  index_out;
  logic [3:0]  data_index_out;

  collector dut (
    .clk                         (clk),
    .reset                       (reset),
    .qspi_data                   (qspi_data),
    .qspi_sending                (qspi_sending),
    .qspi_ready                  (qspi_ready),
    .encrypters_data             (enc_data),
    .encrypters_data_ready       (enc_ready),
    .encrypters_capture          (enc_capture),
    .state_out                   (state_out),
    .encrypter_data_packe_out    (packet_out),
    .encrypter_data_subindex_out (subindex_out),
    .encrypter_index_out         (index_out),
    .encrypter_data_index_out    (data_index_out)
  );

  always #5 clk = ~clk;

  logic [3:0] nib_q [$];
  logic [3:0] cap_q [$];
  int m_chk = 0, m_pass = 0;
  int d_chk = 0, d_pass = 0;

  // Monitor: every valid nibble and every capture pulse must match the queue.
  always @(negedge clk) begin
    if (qspi_sending) begin
      m_chk++;
      if (nib_q.size() == 0) begin
        $display("FAIL nibble: got %h, none expected", qspi_data);
      end else begin
        logic [3:0] e;
        e = nib_q.pop_front();
        if (qspi_data == e) begin
          m_pass++;
          $display("nibble %h ok", qspi_data);
        end else $display("FAIL nibble: got %h, expected %h", qspi_data, e);
      end
    end
    if (enc_capture != 4'b0000) begin
      m_chk++;
      if (cap_q.size() == 0) begin
        $display("FAIL capture: got %b, none expected", enc_capture);
      end else begin
        logic [3:0] e;
        e = cap_q.pop_front();
        if (enc_capture == e) begin
          m_pass++;
          $display("capture %b ok", enc_capture);
        end else $display("FAIL capture: got %b, expected %b", enc_capture, e);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    d_chk++;
    if (act === exp) d_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, 64'(state_out), 64'd0);
    chk({tag, " index"}, 64'(index_out), 64'd0);
    chk({tag, " packet"}, 64'(packet_out), 64'd0);
    chk({tag, " data_index"}, 64'(data_index_out), 64'd0);
    chk({tag, " subindex"}, 64'(subindex_out), 64'd0);
    chk({tag, " qspi_data"}, 64'(qspi_data), 64'd0);
    chk({tag, " sending"}, 64'(qspi_sending), 64'd0);
    chk({tag, " capture"}, 64'(enc_capture), 64'd0);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [3:0] cap);
    for (int i = 7; i >= 0; i--) nib_q.push_back(w[i*4 +: 4]);
    cap_q.push_back(cap);
  endtask

  // Drive the encrypters until all raised words are sent, dropping each
  // ready bit on its capture pulse. Optional stall or reset after N nibbles.
  task automatic run_words(input string name, input int stall_after, input int reset_after,
                           input bit contig, input int exp_sent);
    int sent = 0, first = -1, last = -1;
    bit stalled = 0, done = 0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk); #1;
      enc_ready = enc_ready & ~enc_capture;
      if (qspi_sending) begin
        sent++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (stall_after > 0 && sent == stall_after && !stalled) begin
        stalled = 1;
        qspi_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk); #1;
          chk({name, " stall sending"}, 64'(qspi_sending), 64'd0);
          chk({name, " stall data_index"}, 64'(data_index_out), 64'(stall_after));
        end
        qspi_ready = 1'b1;
      end
      if (reset_after > 0 && sent == reset_after) begin
        reset = 1'b1;
        return;
      end
      if (enc_ready == 4'b0000 && nib_q.size() == 0 && cap_q.size() == 0 &&
          state_out == 2'd0 && !qspi_sending) done = 1;
    end
    chk({name, " completed"}, 64'(done), 64'd1);
    chk({name, " nibble count"}, 64'(sent), 64'(exp_sent));
    if (contig) chk({name, " contiguous"}, 64'(last - first + 1), 64'(exp_sent));
    $display("%s: %0d nibbles sent", name, sent);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) enc_data[i] = 32'h0;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    // Idle polling: index walks 0,1,2,3,0... with nothing ready
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      chk("idle index", 64'(index_out), 64'(k % 4));
      chk("idle capture", 64'(enc_capture), 64'd0);
    end
    $display("idle polling done, index=%0d", index_out);

    // Encrypter 0, uninterrupted word
    enc_data[0] = 32'h12345678;
    push_word(32'h12345678, 4'b0001);
    enc_ready = 4'b0001;
    run_words("enc0", 0, 0, 1'b1, 8);

    // Encrypter 1, leading zero nibbles
    enc_data[1] = 32'h00123458;
    push_word(32'h00123458, 4'b0010);
    enc_ready = 4'b0010;
    run_words("enc1", 0, 0, 1'b1, 8);

    // Flow control stall of 3 cycles after 3 nibbles
    enc_data[2] = 32'hCAFEBABE;
    push_word(32'hCAFEBABE, 4'b0100);
    enc_ready = 4'b0100;
    run_words("stall", 3, 0, 1'b0, 8);

    // Simultaneous ready on 1 and 3 while index=2: 3 first, then 1
    begin
      bit found = 0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(negedge clk); #1;
        if (index_out == 2'd2) found = 1;
      end
      chk("reach index 2", 64'(found), 64'd1);
    end
    enc_data[1] = 32'h13579BDF;
    enc_data[3] = 32'hA5A50FF0;
    push_word(32'hA5A50FF0, 4'b1000);
    push_word(32'h13579BDF, 4'b0010);
    enc_ready = 4'b1010;
    run_words("arbit", 0, 0, 1'b0, 16);

    // Reset during SEND after 3 nibbles
    enc_data[0] = 32'hDEADBEEF;
    nib_q.push_back(4'hD);
    nib_q.push_back(4'hE);
    nib_q.push_back(4'hA);
    cap_q.push_back(4'b0001);
    enc_ready = 4'b0001;
    run_words("midreset", 0, 3, 1'b0, 3);
    @(negedge clk); #1;
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("post-reset nibbles left", 64'(nib_q.size()), 64'd0);
    chk("post-reset captures left", 64'(cap_q.size()), 64'd0);

    $display("%0d/%0d checks passed", d_pass + m_pass, d_chk + m_chk);
    $finish;
  end

endmodule
